// File: rtl/stepper_pkg.sv
// stepper_pkg: definitions shared by the coil driver and the phase decoder.
//   - PH_0..PH_3 : energized coil codes {jb1,jb2,jb3,jb4} for phase index 0..3
//   - PH_OFF     : de-energized code
//   - state_e    : decoder lock state
//   - decode_phase() : maps a 4-bit coil code to {legal, off, idx}
package stepper_pkg;

    localparam logic [3:0] PH_0   = 4'b1001;
    localparam logic [3:0] PH_1   = 4'b1010;
    localparam logic [3:0] PH_2   = 4'b0110;
    localparam logic [3:0] PH_3   = 4'b0101;
    localparam logic [3:0] PH_OFF = 4'b0000;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    typedef struct packed {
        logic       legal;  // one of the four energized codes
        logic       off;    // all coils de-energized
        logic [1:0] idx;    // phase index, meaningful only when legal
    } phase_dec_t;

    function automatic phase_dec_t decode_phase(input logic [3:0] code);
        phase_dec_t d;
        d = '0;
        case (code)
            PH_0:    begin d.legal = 1'b1; d.idx = 2'd0; end
            PH_1:    begin d.legal = 1'b1; d.idx = 2'd1; end
            PH_2:    begin d.legal = 1'b1; d.idx = 2'd2; end
            PH_3:    begin d.legal = 1'b1; d.idx = 2'd3; end
            PH_OFF:  d.off = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_if.sv
// stepper_phase_decoder_if: coil observation inputs and decoded readout.
//   master : drives phase_in/home/clear_error, observes readout
//   slave  : the decoder side
interface stepper_phase_decoder_if #(
    parameter int POS_WIDTH = 16
);
    logic [3:0]           phase_in;
    logic                 home;
    logic                 clear_error;
    logic                 step_pulse;
    logic                 step_dir;
    logic [POS_WIDTH-1:0] position;
    logic [1:0]           phase_idx;
    logic                 phase_valid;
    logic                 error;
    logic                 moving;

    modport master (
        output phase_in, home, clear_error,
        input  step_pulse, step_dir, position, phase_idx, phase_valid, error, moving
    );

    modport slave (
        input  phase_in, home, clear_error,
        output step_pulse, step_dir, position, phase_idx, phase_valid, error, moving
    );
endinterface

// File: rtl/phase_filter.sv
// phase_filter: 2-flop synchronizer plus stability filter for the coil pattern.
//   clk, rst_n    : clock, async active-low reset
//   phase_in      : raw asynchronous coil pattern
//   commit_code   : pattern being committed (valid while commit is high)
//   commit        : one-cycle strobe when a new stable pattern is accepted
module phase_filter #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] phase_in,
    output logic [3:0] commit_code,
    output logic       commit
);
    localparam int              CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    committed_q, committed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            committed_q <= '0;
        end else begin
            sync1_q     <= phase_in;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
        end
    end

    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        commit      = 1'b0;
        commit_code = cand_q;

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Counter saturates, so a stable candidate commits exactly once.
        if (cnt_q == CNT_MAX && cand_q != committed_q && sync2_q == cand_q) begin
            commit      = 1'b1;
            committed_d = cand_q;
        end
    end
endmodule

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: decodes the observed 4-phase coil pattern into step
// events, direction and a signed position count; flags illegal codes and skips.
//   CLK100MHZ : system clock
//   resetn    : async active-low reset
//   bus       : slave side of stepper_phase_decoder_if
//               in : phase_in, home, clear_error
//               out: step_pulse, step_dir, position, phase_idx, phase_valid,
//                    error, moving
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int POS_WIDTH     = 16,
    parameter int IDLE_CYCLES   = 3_000_000
) (
    input  logic                    CLK100MHZ,
    input  logic                    resetn,
    stepper_phase_decoder_if.slave  bus
);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    logic [3:0]  commit_code;
    logic        commit;
    phase_dec_t  dec;

    state_e                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;
    logic                   step_pulse_q, step_pulse_d;
    logic                   step_dir_q, step_dir_d;
    logic [POS_WIDTH-1:0]   position_q, position_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;

    logic                   err_set;
    logic [POS_WIDTH-1:0]   pos_step;
    logic [1:0]             idx_inc, idx_dec, idx_skip;

    phase_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk         (CLK100MHZ),
        .rst_n       (resetn),
        .phase_in    (bus.phase_in),
        .commit_code (commit_code),
        .commit      (commit)
    );

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            state_q      <= UNLOCKED;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
            position_q   <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
            position_q   <= position_d;
            idle_q       <= idle_d;
        end
    end

    always_comb begin
        dec          = decode_phase(commit_code);
        idx_inc      = idx_q + 2'd1;
        idx_dec      = idx_q - 2'd1;
        idx_skip     = idx_q + 2'd2;

        state_d      = state_q;
        idx_d        = idx_q;
        valid_d      = valid_q;
        err_set      = 1'b0;
        step_pulse_d = 1'b0;
        step_dir_d   = step_dir_q;
        pos_step     = position_q;

        if (commit) begin
            case (state_q)
                UNLOCKED: begin
                    if (dec.legal) begin
                        idx_d   = dec.idx;
                        valid_d = 1'b1;
                        state_d = LOCKED;
                    end else if (dec.off) begin
                        valid_d = 1'b0;
                    end else begin
                        err_set = 1'b1;
                        valid_d = 1'b0;
                    end
                end
                LOCKED: begin
                    if (dec.legal) begin
                        idx_d   = dec.idx;
                        valid_d = 1'b1;
                        // Equal index (return from OFF to the same phase) is not a step.
                        if (dec.idx == idx_inc) begin
                            step_pulse_d = 1'b1;
                            step_dir_d   = 1'b1;
                            pos_step     = position_q + POS_WIDTH'(1);
                        end else if (dec.idx == idx_dec) begin
                            step_pulse_d = 1'b1;
                            step_dir_d   = 1'b0;
                            pos_step     = position_q - POS_WIDTH'(1);
                        end else if (dec.idx == idx_skip) begin
                            err_set = 1'b1;
                        end
                    end else if (dec.off) begin
                        valid_d = 1'b0;
                    end else begin
                        err_set = 1'b1;
                        valid_d = 1'b0;
                        state_d = UNLOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end

        position_d = bus.home ? '0 : pos_step;

        if (err_set)
            error_d = 1'b1;
        else if (bus.clear_error)
            error_d = 1'b0;
        else
            error_d = error_q;

        if (step_pulse_q)
            idle_d = IDLE_W'(IDLE_CYCLES);
        else if (idle_q != '0)
            idle_d = idle_q - IDLE_W'(1);
        else
            idle_d = '0;
    end

    assign bus.step_pulse  = step_pulse_q;
    assign bus.step_dir    = step_dir_q;
    assign bus.position    = position_q;
    assign bus.phase_idx   = idx_q;
    assign bus.phase_valid = valid_q;
    assign bus.error       = error_q;
    assign bus.moving      = (idle_q != '0);
endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb_stepper_phase_decoder: directed self-checking bench for stepper_phase_decoder.
module tb_stepper_phase_decoder;
    import stepper_pkg::*;

    localparam int STABLE = 16;
    localparam int PW     = 16;
    localparam int IDLE   = 64;
    localparam int SETTLE = 25;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   total_pulses = 0;
    int   base_pulses = 0;

    always #5 clk = ~clk;

    stepper_phase_decoder_if #(.POS_WIDTH(PW)) bus ();

    stepper_phase_decoder #(
        .STABLE_CYCLES (STABLE),
        .POS_WIDTH     (PW),
        .IDLE_CYCLES   (IDLE)
    ) dut (
        .CLK100MHZ (clk),
        .resetn    (resetn),
        .bus       (bus)
    );

    always @(posedge clk) begin
        if (bus.step_pulse) total_pulses <= total_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] code, input int n);
        bus.phase_in = code;
        cycles(n);
    endtask

    task automatic mark();
        base_pulses = total_pulses;
    endtask

    initial begin
        bus.phase_in    = PH_OFF;
        bus.home        = 1'b0;
        bus.clear_error = 1'b0;
        cycles(3);

        // Reset state
        check("rst_pulse",  32'(bus.step_pulse), 32'h0);
        check("rst_dir",    32'(bus.step_dir), 32'h0);
        check("rst_pos",    32'(bus.position), 32'h0);
        check("rst_idx",    32'(bus.phase_idx), 32'h0);
        check("rst_valid",  32'(bus.phase_valid), 32'h0);
        check("rst_error",  32'(bus.error), 32'h0);
        check("rst_moving", 32'(bus.moving), 32'h0);
        resetn = 1'b1;
        cycles(2);

        // Test 1: first legal code locks without a step
        mark();
        drive(PH_0, SETTLE);
        check("t1_idx",    32'(bus.phase_idx), 32'h0);
        check("t1_valid",  32'(bus.phase_valid), 32'h1);
        check("t1_pulses", 32'(total_pulses - base_pulses), 32'h0);
        check("t1_pos",    32'(bus.position), 32'h0);

        // Test 2: four CW steps, then idle
        mark();
        drive(PH_1, 20);
        drive(PH_2, 20);
        drive(PH_3, 20);
        drive(PH_0, SETTLE);
        check("t2_pulses", 32'(total_pulses - base_pulses), 32'h4);
        check("t2_dir",    32'(bus.step_dir), 32'h1);
        check("t2_pos",    32'(bus.position), 32'h4);
        check("t2_moving", 32'(bus.moving), 32'h1);
        cycles(70);
        check("t2_idle",   32'(bus.moving), 32'h0);

        // Test 3: glitch shorter than the filter window is ignored
        drive(PH_1, 20);
        drive(PH_2, SETTLE);
        check("t3_pre_pos", 32'(bus.position), 32'h6);
        mark();
        drive(PH_3, 5);
        drive(PH_2, SETTLE);
        check("t3_pulses", 32'(total_pulses - base_pulses), 32'h0);
        check("t3_pos",    32'(bus.position), 32'h6);
        check("t3_idx",    32'(bus.phase_idx), 32'h2);

        // Test 4: 2-phase skip sets sticky error; clear_error clears it
        drive(PH_1, 20);
        drive(PH_0, SETTLE);
        check("t4_pre_pos", 32'(bus.position), 32'h4);
        check("t4_pre_err", 32'(bus.error), 32'h0);
        mark();
        drive(PH_2, SETTLE);
        check("t4_err",    32'(bus.error), 32'h1);
        check("t4_pulses", 32'(total_pulses - base_pulses), 32'h0);
        check("t4_idx",    32'(bus.phase_idx), 32'h2);
        check("t4_pos",    32'(bus.position), 32'h4);
        cycles(5);
        check("t4_sticky", 32'(bus.error), 32'h1);
        bus.clear_error = 1'b1;
        cycles(1);
        bus.clear_error = 1'b0;
        check("t4_clr",    32'(bus.error), 32'h0);

        // Test 5: CCW wrap below zero, then home overriding a step
        drive(PH_1, 20);
        drive(PH_0, SETTLE);
        bus.home = 1'b1;
        cycles(1);
        bus.home = 1'b0;
        check("t5_home0",  32'(bus.position), 32'h0);
        mark();
        drive(PH_3, SETTLE);
        check("t5_pulses", 32'(total_pulses - base_pulses), 32'h1);
        check("t5_dir",    32'(bus.step_dir), 32'h0);
        check("t5_wrap",   32'(bus.position), 32'hFFFF);
        mark();
        bus.home = 1'b1;
        drive(PH_2, SETTLE);
        check("t5_h_pos",  32'(bus.position), 32'h0);
        check("t5_h_puls", 32'(total_pulses - base_pulses), 32'h1);
        check("t5_h_dir",  32'(bus.step_dir), 32'h0);
        check("t5_h_idx",  32'(bus.phase_idx), 32'h2);
        bus.home = 1'b0;

        // Test 6: OFF retains index; illegal code unlocks; async reset
        drive(PH_1, SETTLE);
        check("t6_ccw_pos", 32'(bus.position), 32'hFFFF);
        mark();
        drive(PH_OFF, SETTLE);
        check("t6_off_val", 32'(bus.phase_valid), 32'h0);
        check("t6_off_idx", 32'(bus.phase_idx), 32'h1);
        check("t6_off_pul", 32'(total_pulses - base_pulses), 32'h0);
        drive(PH_2, SETTLE);
        check("t6_ret_pul", 32'(total_pulses - base_pulses), 32'h1);
        check("t6_ret_dir", 32'(bus.step_dir), 32'h1);
        check("t6_ret_pos", 32'(bus.position), 32'h0);
        check("t6_ret_val", 32'(bus.phase_valid), 32'h1);
        drive(4'b1111, SETTLE);
        check("t6_ill_err", 32'(bus.error), 32'h1);
        check("t6_ill_val", 32'(bus.phase_valid), 32'h0);
        mark();
        drive(PH_3, SETTLE);
        check("t6_rl_pul",  32'(total_pulses - base_pulses), 32'h0);
        check("t6_rl_idx",  32'(bus.phase_idx), 32'h3);
        check("t6_rl_val",  32'(bus.phase_valid), 32'h1);
        check("t6_rl_pos",  32'(bus.position), 32'h0);
        drive(PH_0, 8);
        resetn = 1'b0;
        #1;
        check("t6_r_err",   32'(bus.error), 32'h0);
        check("t6_r_val",   32'(bus.phase_valid), 32'h0);
        check("t6_r_idx",   32'(bus.phase_idx), 32'h0);
        check("t6_r_dir",   32'(bus.step_dir), 32'h0);
        check("t6_r_puls",  32'(bus.step_pulse), 32'h0);
        check("t6_r_mov",   32'(bus.moving), 32'h0);
        cycles(3);
        resetn = 1'b1;
        mark();
        drive(PH_0, SETTLE);
        check("t6_post_pul", 32'(total_pulses - base_pulses), 32'h0);
        check("t6_post_idx", 32'(bus.phase_idx), 32'h0);
        check("t6_post_val", 32'(bus.phase_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
